// File: rtl/dumpoff_monitor.sv
// Consumer-side checker for the DUMPOFF dump-switch line.
// Armed by state_start, it measures the dumpoff high width and flags timing faults.
module dumpoff_monitor #(
    parameter int CNT_W   = 16,
    parameter int RISE_TO = 64,
    parameter int MIN_W   = 4,
    parameter int MAX_W   = 4096
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             state_start,
    input  logic             dumpoff,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] width,
    output logic             err_norise,
    output logic             err_short,
    output logic             err_stuck,
    output logic             err_retrig
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_MEAS
    } state_t;

    localparam logic [CNT_W-1:0] L_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] L_RISE_LAST = CNT_W'(RISE_TO - 1);
    localparam logic [CNT_W-1:0] L_MIN_W     = CNT_W'(MIN_W);
    localparam logic [CNT_W-1:0] L_MAX_W     = CNT_W'(MAX_W);

    state_t           r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] r_width_cnt;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_width;
    logic             r_err_norise;
    logic             r_err_short;
    logic             r_err_stuck;
    logic             r_err_retrig;

    state_t           w_state;
    logic [CNT_W-1:0] w_wait_cnt;
    logic [CNT_W-1:0] w_width_cnt;
    logic             w_busy;
    logic             w_done;
    logic [CNT_W-1:0] w_width;
    logic             w_err_norise;
    logic             w_err_short;
    logic             w_err_stuck;
    logic             w_err_retrig;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= '0;
            r_width_cnt  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_width      <= '0;
            r_err_norise <= 1'b0;
            r_err_short  <= 1'b0;
            r_err_stuck  <= 1'b0;
            r_err_retrig <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_wait_cnt   <= w_wait_cnt;
            r_width_cnt  <= w_width_cnt;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_width      <= w_width;
            r_err_norise <= w_err_norise;
            r_err_short  <= w_err_short;
            r_err_stuck  <= w_err_stuck;
            r_err_retrig <= w_err_retrig;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state      = r_state;
        w_wait_cnt   = r_wait_cnt;
        w_width_cnt  = r_width_cnt;
        w_busy       = r_busy;
        w_done       = 1'b0;
        w_width      = r_width;
        w_err_norise = r_err_norise;
        w_err_short  = r_err_short;
        w_err_stuck  = r_err_stuck;
        w_err_retrig = r_err_retrig;

        // A start during a measurement is only flagged; the measurement runs on.
        if (state_start && r_busy) begin
            w_err_retrig = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (state_start) begin
                    w_state      = S_WAIT;
                    w_wait_cnt   = '0;
                    w_busy       = 1'b1;
                    w_err_norise = 1'b0;
                    w_err_short  = 1'b0;
                    w_err_stuck  = 1'b0;
                    w_err_retrig = 1'b0;
                end
            end
            S_WAIT: begin
                if (dumpoff) begin
                    w_state     = S_MEAS;
                    w_width_cnt = L_ONE;
                end else if (r_wait_cnt == L_RISE_LAST) begin
                    w_state      = S_IDLE;
                    w_width      = '0;
                    w_err_norise = 1'b1;
                    w_done       = 1'b1;
                    w_busy       = 1'b0;
                end else begin
                    w_wait_cnt = r_wait_cnt + L_ONE;
                end
            end
            S_MEAS: begin
                if (!dumpoff) begin
                    w_state     = S_IDLE;
                    w_width     = r_width_cnt;
                    w_err_short = (r_width_cnt < L_MIN_W);
                    w_done      = 1'b1;
                    w_busy      = 1'b0;
                end else if (r_width_cnt == L_MAX_W) begin
                    // The (MAX_W+1)-th high sample: report the cap, not a wrap.
                    w_state     = S_IDLE;
                    w_width     = L_MAX_W;
                    w_err_stuck = 1'b1;
                    w_done      = 1'b1;
                    w_busy      = 1'b0;
                end else begin
                    w_width_cnt = r_width_cnt + L_ONE;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
            end
        endcase
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign width      = r_width;
    assign err_norise = r_err_norise;
    assign err_short  = r_err_short;
    assign err_stuck  = r_err_stuck;
    assign err_retrig = r_err_retrig;

endmodule

// File: doc/dumpoff_monitor.md
Name: dumpoff_monitor

Overview:
Consumer-side checker for the dump-switch control line produced by the DUMPOFF sequencer. It is armed by the same `state_start` pulse that launches the sequencer and measures how long `dumpoff` stays high. It then reports completion, width and timing faults to the pulse-sequence controller. It sits in the `clk_sys` domain next to DUMPOFF; no synchronizer is needed.

Parameters:
- CNT_W, 16, width of the cycle counters and of `width`.
- RISE_TO, 64, maximum number of `clk_sys` cycles to wait for `dumpoff` high after arming.
- MIN_W, 4, minimum legal high width in cycles.
- MAX_W, 4096, maximum legal high width in cycles; must be less than 2^CNT_W.

Ports:
- clk_sys, in, 1, system clock; all logic on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- state_start, in, 1, single-cycle arm pulse, shared with the DUMPOFF sequencer.
- dumpoff, in, 1, dump-switch line under observation; high means the switch is asserted.
- busy, out, 1, high while a measurement is in progress.
- done, out, 1, single-cycle completion pulse.
- width, out, CNT_W, measured high width in cycles; held until the next `done`.
- err_norise, out, 1, `dumpoff` never went high within RISE_TO cycles.
- err_short, out, 1, measured width was below MIN_W.
- err_stuck, out, 1, `dumpoff` stayed high longer than MAX_W cycles.
- err_retrig, out, 1, `state_start` arrived while `busy`.

Behaviour:
- Interface: one clock, `clk_sys`. Reset `rst_n` is asynchronous and active-low.
- Reset: FSM goes to IDLE. busy=0, done=0, width=0, all err_* = 0, internal counters 0. Applies immediately, including mid-measurement; nothing is reported for the aborted measurement.
- FSM states: IDLE, WAIT, MEAS. All outputs are registered.
- IDLE:
  - `dumpoff` is ignored.
  - On `state_start`=1: go to WAIT, wait_cnt=0, busy=1, clear err_norise, err_short, err_stuck and err_retrig. `width` keeps its old value.
- WAIT:
  - `dumpoff`=1 sampled: go to MEAS, width_cnt=1. This is level-sensitive, so a line already high on entry counts.
  - `dumpoff`=0 and wait_cnt==RISE_TO-1: go to IDLE, width=0, err_norise=1, done=1, busy=0.
  - Otherwise: wait_cnt+1.
- MEAS:
  - `dumpoff`=0 sampled: go to IDLE, width=width_cnt, err_short=(width_cnt<MIN_W), done=1, busy=0.
  - `dumpoff`=1 and width_cnt==MAX_W: go to IDLE, width=MAX_W, err_stuck=1, done=1, busy=0. This is the cycle-(MAX_W+1) high sample.
  - Otherwise: width_cnt+1.
  - `width` therefore equals the number of rising edges at which `dumpoff` was sampled high, capped at MAX_W.
- Latency:
  - `done`, `width` and err_* update on the same edge that samples the falling level, timeout or cap.
  - They are visible in the following cycle.
  - `done` is high for exactly one cycle, then returns to 0.
- Retrigger:
  - `state_start` while busy=1 is ignored: the measurement continues and counters are untouched.
  - It sets err_retrig=1, which stays set until the next accepted start.
- Start coincident with `done`: the FSM is already in IDLE in the `done` cycle, so a `state_start` in that cycle is accepted normally.
- Output hold: err_* and `width` hold between `done` pulses. err_* are cleared only by an accepted start or by reset.
- Counters never wrap: wait_cnt is bounded by RISE_TO and width_cnt by MAX_W.

Test Plan (RISE_TO=8, MIN_W=3, MAX_W=20):
1. Nominal: `state_start`, `dumpoff` high 3 cycles later for 10 cycles -> one `done` pulse the cycle after the low sample; width=10; all err_*=0; busy high for 13 cycles.
2. No rise: `state_start`, `dumpoff` held 0 -> `done` after 8 WAIT cycles; width=0; err_norise=1; busy=0 afterwards.
3. Short pulse: `dumpoff` high 2 cycles -> width=2, err_short=1. Repeat with 3 cycles -> width=3, err_short=0.
4. Stuck: `dumpoff` held high -> `done` after the 21st high sample; width=20; err_stuck=1. A later falling edge produces no further `done`.
5. Retrigger: second `state_start` 5 cycles into MEAS of a 10-cycle pulse -> one `done` only; width=10; err_retrig=1. The next accepted start clears err_retrig.
6. Reset mid-MEAS: pull `rst_n` low for 1 cycle -> all outputs 0 immediately. The subsequent `dumpoff` fall yields no `done`; a fresh `state_start` with a 5-cycle pulse gives width=5.
